// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector: loadable serial pattern detector with saturating match counter
module prog_sequence_detector #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             load,
  input  logic [PAT_LEN-1:0]               pattern_in,
  input  logic                             w,
  input  logic                             valid,
  input  logic                             clear,
  output logic                             armed,
  output logic                             match,
  output logic [$clog2(PAT_LEN+1)-1:0]     fill,
  output logic [CNT_W-1:0]                 match_count
);
  localparam int FW = $clog2(PAT_LEN+1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  typedef enum logic {UNLOADED, RUN} state_t;
  state_t state, state_nx;
  logic [PAT_LEN-1:0] pattern, history, hist_nx;
  logic [FW-1:0] fill_inc;
  logic sample, hit;
  always_comb begin
    state_nx = load ? RUN : state;
    sample   = (state == RUN) && valid && !load;
    hist_nx  = {history[PAT_LEN-2:0], w};
    fill_inc = (fill == FULL) ? fill : fill + 1'b1;
    hit      = sample && (fill_inc == FULL) && (hist_nx == pattern);
  end
  assign armed = (state == RUN);
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= UNLOADED;
      pattern     <= '0;
      history     <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_nx;
      match <= hit;
      if (load) begin
        pattern <= pattern_in;
        history <= '0;
        fill    <= '0;
      end else if (sample) begin
        history <= hist_nx;
        // non-overlapping mode restarts the fill so consumed bits cannot match again
        fill    <= (hit && OVERLAP == 0) ? '0 : fill_inc;
      end
      match_count <= clear ? '0 : (hit && !(&match_count)) ? match_count + 1'b1 : match_count;
    end
  end
endmodule

// File: tb/tb_prog_sequence_detector.sv
// tb_prog_sequence_detector: directed checks of overlapping, non-overlapping and narrow-counter variants
module tb_prog_sequence_detector;
  logic clock = 1'b0, resetn = 1'b0, load = 1'b0, w = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [3:0] pattern_in = '0;
  logic arm1, m1, arm0, m0, arm2, m2;
  logic [2:0] f1, f0, f2;
  logic [7:0] c1, c0;
  logic [1:0] c2;
  int checks = 0, passed = 0;

  always #5 clock = ~clock;

  prog_sequence_detector d1 (.clock(clock), .resetn(resetn), .load(load), .pattern_in(pattern_in),
    .w(w), .valid(valid), .clear(clear), .armed(arm1), .match(m1), .fill(f1), .match_count(c1));
  prog_sequence_detector #(.OVERLAP(0)) d0 (.clock(clock), .resetn(resetn), .load(load),
    .pattern_in(pattern_in), .w(w), .valid(valid), .clear(clear), .armed(arm0), .match(m0),
    .fill(f0), .match_count(c0));
  prog_sequence_detector #(.CNT_W(2)) d2 (.clock(clock), .resetn(resetn), .load(load),
    .pattern_in(pattern_in), .w(w), .valid(valid), .clear(clear), .armed(arm2), .match(m2),
    .fill(f2), .match_count(c2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic l, input logic [3:0] p, input logic v, input logic b, input logic c);
    load = l; pattern_in = p; valid = v; w = b; clear = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [6:0] s7;
    logic [6:0] e1, e0;
    logic [7:0] e2c;
    logic [7:0] e1m, e0m;
    #1;
    step(1, 4'b1101, 1, 1, 0);
    check("rst_armed", arm1, 0);
    check("rst_match", m1, 0);
    check("rst_fill", f1, 0);
    check("rst_count", c1, 0);
    resetn = 1;
    step(0, 0, 1, 1, 0);
    check("unl_fill", f1, 0);
    check("unl_match", m1, 0);
    check("unl_armed", arm1, 0);
    step(1, 4'b1101, 1, 1, 0);
    check("ld_armed", arm1, 1);
    check("ld_fill_w_discard", f1, 0);
    s7 = 7'b1101101; e1 = 7'b0001001; e0 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1, s7[i], 0);
      check($sformatf("ov_match_b%0d", 7 - i), m1, e1[i]);
      check($sformatf("nov_match_b%0d", 7 - i), m0, e0[i]);
      if (i == 5) check("ov_fill_b2", f1, 2);
    end
    check("ov_count", c1, 2);
    check("nov_count", c0, 1);
    check("nov_fill_end", f0, 3);
    check("ov_fill_end", f1, 4);
    step(0, 0, 0, 1, 0);
    check("idle_match", m1, 0);
    step(1, 4'b1111, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      check($sformatf("gap_match_%0d", i), m1, 0);
      check($sformatf("gap_fill_%0d", i), f1, 2);
    end
    step(0, 0, 1, 1, 0);
    check("gap_b3_match", m1, 0);
    step(0, 0, 1, 1, 0);
    check("gap_final_match", m1, 1);
    check("gap_count", c1, 3);
    step(0, 0, 0, 0, 1);
    check("clear_count", c1, 0);
    check("clear_count2", c2, 0);
    check("clear_match", m1, 0);
    step(1, 4'b1111, 0, 0, 0);
    e2c = 0;
    e1m = 8'b00011111; e0m = 8'b00010001;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 0);
      if (e1m[7 - i] && e2c != 3) e2c++;
      check($sformatf("sat_count_%0d", i), c2, e2c);
      check($sformatf("ones_ov_match_%0d", i), m1, e1m[7 - i]);
      check($sformatf("ones_nov_match_%0d", i), m0, e0m[7 - i]);
    end
    check("ones_ov_count", c1, 5);
    check("ones_nov_count", c0, 2);
    check("sat_count_end", c2, 3);
    step(0, 0, 1, 1, 1);
    check("clr_hit_match", m1, 1);
    check("clr_hit_count", c1, 0);
    check("clr_nov_match", m0, 0);
    step(1, 4'b1101, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    check("mid_fill", f1, 3);
    resetn = 0;
    step(0, 0, 1, 1, 0);
    check("mid_rst_armed", arm1, 0);
    check("mid_rst_fill", f1, 0);
    check("mid_rst_count2", c2, 0);
    resetn = 1;
    s7 = 7'b0001101;
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 1, s7[i], 0);
      check($sformatf("post_rst_match_%0d", i), m1, 0);
    end
    check("post_rst_fill", f1, 0);
    step(1, 4'b1101, 1, 1, 0);
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 1, s7[i], 0);
      check($sformatf("reload_match_%0d", i), m1, (i == 0));
    end
    check("reload_count", c1, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/prog_sequence_detector.md
PROG_SEQUENCE_DETECTOR -- requirements
Module: prog_sequence_detector

Interface
REQ-001 Parameter PAT_LEN, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter OVERLAP, default 1; 1 = overlapping matches, 0 = non-overlapping.
REQ-004 clock  input  1  rising-edge clock; all state updates on this edge only.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 load  input  1  load pattern_in as the new target pattern and arm the detector.
REQ-007 pattern_in  input  PAT_LEN  target pattern; bit PAT_LEN-1 is the first bit in time, bit 0 the last.
REQ-008 w  input  1  serial data bit.
REQ-009 valid  input  1  w is sampled only on edges where valid=1.
REQ-010 clear  input  1  zero match_count.
REQ-011 armed  output  1  1 when in state RUN.
REQ-012 match  output  1  registered one-cycle pulse per detected match.
REQ-013 fill  output  clog2(PAT_LEN+1)  number of valid history bits, saturating at PAT_LEN.
REQ-014 match_count  output  CNT_W  number of matches since reset/clear, saturating.

Function
REQ-015 Two states: UNLOADED (no pattern, input ignored) and RUN (detecting).
REQ-016 UNLOADED -> RUN on any edge with load=1; RUN -> RUN on load (re-arm); no other transitions except reset.
REQ-017 On load: pattern register <= pattern_in, history <= 0, fill <= 0, match <= 0; match_count unchanged.
REQ-018 load has priority over valid on the same edge; that cycle's w is discarded.
REQ-019 In RUN with valid=1 and load=0: history <= {history[PAT_LEN-2:0], w}; fill <= min(fill+1, PAT_LEN).
REQ-020 Match event on a sampling edge iff the updated fill equals PAT_LEN and the updated history equals the pattern register.
REQ-021 match is 1 for exactly the cycle after the edge carrying the final pattern bit (latency 1); otherwise 0, including on edges with valid=0.
REQ-022 OVERLAP=1: fill stays PAT_LEN after a match; the next matching bit can produce a match on the immediately following sample.
REQ-023 OVERLAP=0: on a match event fill <= 0; history bits are retained but are not considered until fill reaches PAT_LEN again.
REQ-024 On each match event match_count <= match_count+1, held at 2^CNT_W-1 (no wrap-around).
REQ-025 clear=1 sets match_count <= 0 and wins over a same-edge match event (count 0); match still pulses.
REQ-026 In UNLOADED: valid/w ignored, match=0, fill=0; clear still honoured.
REQ-027 Gaps in valid do not reset history or fill; detection spans gaps.

Reset
REQ-028 resetn=0 at an edge: state UNLOADED, pattern 0, history 0, fill 0, match 0, armed 0, match_count 0.
REQ-029 Reset overrides load, valid and clear on the same edge; reset mid-pattern discards partial history.

Verification
REQ-030 PAT_LEN=4, OVERLAP=1, load 1101, stream 1,1,0,1,1,0,1 (valid=1) -> match pulses after bits 4 and 7, match_count=2.
REQ-031 Same stream with OVERLAP=0 -> single match after bit 4, fill=3 at end, match_count=1.
REQ-032 load 1111, stream 1,1 then valid=0 for 3 cycles then 1,1 -> one match after final bit, no match during gap.
REQ-033 CNT_W=2, pattern 1111, OVERLAP=1, stream of eight 1s -> match_count reaches 3 and stays 3.
REQ-034 clear asserted on the edge of a match event -> match=1 next cycle, match_count=0.
REQ-035 Mid-pattern (fill=3) assert resetn=0 then feed pattern -> no match until load; after load, full pattern required before match.
